// File: rtl/uba_dma_arbiter.sv
// Round-robin sequencer sharing the UBA-to-KS10 bus request path among NREQ
// Unibus DMA requesters, with its own no-acknowledge timeout.
//
// state | meaning
// IDLE  | waiting for any devREQ; picks winner from ptr and latches its address
// REQ   | busREQO asserted for one cycle; early busACKI short-cuts to DONE
// WAIT  | counting down from TIMEOUT for busACKI; count==1 without ack is a timeout
// DONE  | one-cycle devACK or devTMO/setTMO pulse; advance round-robin pointer

module uba_dma_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 36,
    parameter int TIMEOUT = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      devREQ,
    input  logic [NREQ*AW-1:0]   devADDR,
    input  logic                 busACKI,
    output logic                 busREQO,
    output logic [AW-1:0]        busADDRO,
    output logic [NREQ-1:0]      devACK,
    output logic [NREQ-1:0]      devTMO,
    output logic                 setTMO,
    output logic [2:0]           gntIDX,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic [3:0]      count;
    logic [2:0]      ptr;
    logic            found;
    logic [2:0]      win;
    logic [3:0]      sum;
    logic [AW-1:0]   addr_sel;
    logic [NREQ-1:0] gnt_oh;
    logic [2:0]      ptr_next;

    // Scan offsets 0..NREQ-1 from ptr; constant inner loop keeps all indices static.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(NREQ))
                sum = sum - 4'(NREQ);
            for (int k = 0; k < NREQ; k++) begin
                if (!found && sum == 4'(k) && devREQ[k]) begin
                    found = 1'b1;
                    win   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == 3'(k))
                addr_sel = devADDR[k*AW +: AW];
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NREQ; k++)
            gnt_oh[k] = (gntIDX == 3'(k));
    end

    assign ptr_next = (gntIDX == 3'(NREQ-1)) ? 3'd0 : gntIDX + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            ptr      <= '0;
            busREQO  <= 1'b0;
            busADDRO <= '0;
            gntIDX   <= '0;
            devACK   <= '0;
            devTMO   <= '0;
            setTMO   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busREQO <= 1'b0;
            devACK  <= '0;
            devTMO  <= '0;
            setTMO  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gntIDX   <= win;
                        busADDRO <= addr_sel;
                        busREQO  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (busACKI) begin
                        devACK <= gnt_oh;
                        state  <= DONE;
                    end else begin
                        count <= 4'(TIMEOUT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (busACKI) begin
                        devACK <= gnt_oh;
                        state  <= DONE;
                    end else if (count == 4'd1) begin
                        devTMO <= gnt_oh;
                        setTMO <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    ptr   <= ptr_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
